aes_128_decipher_block: RTL and testbench



---
 rtl/aes_128_decipher_block.sv | 161 ++++++++++++++++
 tb/tb_aes_128_decipher_block.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_decipher_block.sv
// Iterative AES-128 inverse cipher, one S-box word per cycle.
// Optional `done` pulse output: define AES_DEC_DONE_PULSE_EN.
module aes_128_decipher_block #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic [127:0] round_key,
    input  logic [31:0]  new_inv_sbox,
    input  logic [127:0] block,
    output logic [3:0]   round,
    output logic [31:0]  inv_sbox,
    output logic [127:0] new_block,
    output logic         ready
`ifdef AES_DEC_DONE_PULSE_EN
    ,
    output logic         done
`endif
);

    typedef enum logic [2:0] {IDLE, INIT, SHIFT, SBOX, MAIN} state_t;

    state_t       fsm, fsm_n;
    logic [127:0] state_n;
    logic [127:0] addk;
    logic [3:0]   round_n;
    logic         ready_n;
    logic [1:0]   cnt, cnt_n;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = w[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
    endfunction

    // Row r of each column is taken from the column r positions to the left.
    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = s;
        return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
                w1[31:24], w0[23:16], w3[15:8], w2[7:0],
                w2[31:24], w1[23:16], w0[15:8], w3[7:0],
                w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
    endfunction

    assign addk = new_block ^ round_key;

    always_comb begin
        inv_sbox = '0;
        if (fsm == SBOX) begin
            unique case (cnt)
                2'd0: inv_sbox = new_block[127:96];
                2'd1: inv_sbox = new_block[95:64];
                2'd2: inv_sbox = new_block[63:32];
                2'd3: inv_sbox = new_block[31:0];
                default: inv_sbox = '0;
            endcase
        end
    end

    always_comb begin
        fsm_n   = fsm;
        state_n = new_block;
        round_n = round;
        ready_n = ready;
        cnt_n   = cnt;
        unique case (fsm)
            IDLE: begin
                if (next) begin
                    round_n = 4'(NUM_ROUNDS);
                    ready_n = 1'b0;
                    fsm_n   = INIT;
                end
            end
            INIT: begin
                state_n = block ^ round_key;
                round_n = round - 4'd1;
                cnt_n   = 2'd0;
                fsm_n   = SHIFT;
            end
            SHIFT: begin
                state_n = inv_shift(new_block);
                fsm_n   = SBOX;
            end
            SBOX: begin
                unique case (cnt)
                    2'd0: state_n[127:96] = new_inv_sbox;
                    2'd1: state_n[95:64]  = new_inv_sbox;
                    2'd2: state_n[63:32]  = new_inv_sbox;
                    2'd3: state_n[31:0]   = new_inv_sbox;
                    default: state_n = new_block;
                endcase
                cnt_n = cnt + 2'd1;
                if (cnt == 2'd3) fsm_n = MAIN;
            end
            MAIN: begin
                if (round == 4'd0) begin
                    state_n = addk;
                    ready_n = 1'b1;
                    fsm_n   = IDLE;
                end else begin
                    state_n = inv_mix(addk);
                    round_n = round - 4'd1;
                    fsm_n   = SHIFT;
                end
            end
            default: fsm_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= IDLE;
            new_block <= '0;
            round     <= '0;
            ready     <= 1'b1;
            cnt       <= '0;
        end else begin
            fsm       <= fsm_n;
            new_block <= state_n;
            round     <= round_n;
            ready     <= ready_n;
            cnt       <= cnt_n;
        end
    end

`ifdef AES_DEC_DONE_PULSE_EN
    always_ff @(posedge clk) begin
        if (reset) done <= 1'b0;
        else       done <= (fsm == MAIN) && (round == 4'd0);
    end
`endif

endmodule

// File: tb/tb_aes_128_decipher_block.sv
// Self-checking bench for aes_128_decipher_block against a
// byte-level FIPS-197 InvCipher model with generated S-box tables.
module tb_aes_128_decipher_block;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset, next;
    logic [127:0] round_key, block, new_block;
    logic [31:0]  new_inv_sbox, inv_sbox;
    logic [3:0]   round;
    logic         ready;
`ifdef AES_DEC_DONE_PULSE_EN
    logic         done;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] rk  [11];
    logic [127:0] exp_shift [10];

    always #5 clk = ~clk;

    aes_128_decipher_block dut (
        .clk          (clk),
        .reset        (reset),
        .next         (next),
        .round_key    (round_key),
        .new_inv_sbox (new_inv_sbox),
        .block        (block),
        .round        (round),
        .inv_sbox     (inv_sbox),
        .new_block    (new_block),
        .ready        (ready)
`ifdef AES_DEC_DONE_PULSE_EN
        ,
        .done         (done)
`endif
    );

    always_comb begin
        new_inv_sbox = {isb[inv_sbox[31:24]], isb[inv_sbox[23:16]],
                        isb[inv_sbox[15:8]], isb[inv_sbox[7:0]]};
        round_key = (round <= 4'd10) ? rk[round] : '0;
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b};
        return 8'(t >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                ^ rotl8(inv, 4) ^ 8'h63;
            sb[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [7:0] gb(input logic [127:0] s, input int c, input int r);
        return s[127-8*(4*c+r) -: 8];
    endfunction

    // Textbook InvCipher on a byte grid; records each round's shifted state.
    task automatic model_decrypt(input logic [127:0] ct, output logic [127:0] pt);
        logic [127:0] s, t;
        logic [7:0]   m [4];
        logic [7:0]   acc;
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        s = ct ^ rk[10];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    t[127-8*(4*c+q) -: 8] = gb(s, (c - q + 4) % 4, q);
            s = t;
            exp_shift[9-r] = s;
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = isb[s[127-8*i -: 8]];
            s = s ^ rk[r];
            if (r > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int q = 0; q < 4; q++) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++)
                            acc = acc ^ gmul(m[(j - q + 4) % 4], gb(s, c, j));
                        t[127-8*(4*c+q) -: 8] = acc;
                    end
                s = t;
            end
        end
        pt = s;
    endtask

    task automatic start(input logic [127:0] blk);
        @(negedge clk);
        block = blk;
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
    endtask

    task automatic wait_ready(input int k0, output int lat);
        lat = k0;
        while (!ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; next = 1'b0; block = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks += 4;
        if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        if (new_block !== '0) begin failures++; $display("FAIL reset_block got=%h exp=0", new_block); end
        if (round !== 4'd0) begin failures++; $display("FAIL reset_round got=%0d exp=0", round); end
        if (inv_sbox !== '0) begin failures++; $display("FAIL reset_sbox got=%h exp=0", inv_sbox); end
`ifdef AES_DEC_DONE_PULSE_EN
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
`endif
    endtask

    task automatic test_fips_b();
        int lat;
        set_key(KEY_B);
        start(CT_B);
        wait_ready(1, lat);
        checks += 2;
        if (lat != 62) begin failures++; $display("FAIL fips_b_latency got=%0d exp=62", lat); end
        if (new_block !== PT_B) begin failures++; $display("FAIL fips_b_result got=%h exp=%h", new_block, PT_B); end
    endtask

    task automatic test_fips_c1();
        int lat;
        logic [127:0] pt;
        set_key(KEY_C);
        model_decrypt(CT_C, pt);
        start(CT_C);
        wait_ready(1, lat);
        checks += 3;
        if (lat != 62) begin failures++; $display("FAIL fips_c1_latency got=%0d exp=62", lat); end
        if (new_block !== PT_C) begin failures++; $display("FAIL fips_c1_result got=%h exp=%h", new_block, PT_C); end
        if (pt !== new_block) begin failures++; $display("FAIL fips_c1_model got=%h exp=%h", new_block, pt); end
    endtask

    task automatic test_round_trace();
        logic [127:0] pt;
        logic [3:0]   er;
        logic [31:0]  es;
        int ph;
        set_key(KEY_B);
        model_decrypt(CT_B, pt);
        start(CT_B);
        for (int k = 1; k <= 62; k++) begin
            if (k > 1) @(negedge clk);
            er = (k == 1) ? 4'd10 : (k == 62) ? 4'd0 : 4'(9 - (k - 2) / 6);
            es = '0;
            if (k >= 2 && k <= 61) begin
                ph = (k - 2) % 6;
                if (ph >= 1 && ph <= 4) es = exp_shift[(k-2)/6][127-32*(ph-1) -: 32];
            end
            checks += 3;
            if (round !== er) begin failures++; $display("FAIL trace_round k=%0d got=%0d exp=%0d", k, round, er); end
            if (inv_sbox !== es) begin failures++; $display("FAIL trace_sbox k=%0d got=%h exp=%h", k, inv_sbox, es); end
            if (ready !== (k == 62)) begin failures++; $display("FAIL trace_ready k=%0d got=%b", k, ready); end
`ifdef AES_DEC_DONE_PULSE_EN
            checks++;
            if (done !== (k == 62)) begin failures++; $display("FAIL trace_done k=%0d got=%b", k, done); end
`endif
        end
        checks++;
        if (new_block !== pt) begin failures++; $display("FAIL trace_result got=%h exp=%h", new_block, pt); end
        @(negedge clk);
`ifdef AES_DEC_DONE_PULSE_EN
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL idle_done got=%b exp=0", done); end
`endif
    endtask

    task automatic test_busy_next();
        int lat = 200;
        logic [127:0] ct, pt;
        set_key(KEY_B);
        start(CT_B);
        for (int k = 2; k <= 100; k++) begin
            @(negedge clk);
            if (ready) begin lat = k; break; end
            next = (k == 5 || k == 30 || k == 61);
        end
        next = 1'b0;
        checks += 2;
        if (lat != 62) begin failures++; $display("FAIL busy_latency got=%0d exp=62", lat); end
        if (new_block !== PT_B) begin failures++; $display("FAIL busy_result got=%h exp=%h", new_block, PT_B); end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL busy_no_queue got=%b exp=1", ready); end
        ct = {$urandom, $urandom, $urandom, $urandom};
        model_decrypt(ct, pt);
        start(ct);
        wait_ready(1, lat);
        checks += 2;
        if (lat != 62) begin failures++; $display("FAIL second_latency got=%0d exp=62", lat); end
        if (new_block !== pt) begin failures++; $display("FAIL second_result got=%h exp=%h", new_block, pt); end
    endtask

    task automatic test_held_next();
        int lat = 200;
        logic [127:0] ct, pt;
        ct = {$urandom, $urandom, $urandom, $urandom};
        model_decrypt(ct, pt);
        @(negedge clk);
        block = ct;
        next = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (ready) begin lat = k; break; end
        end
        checks += 2;
        if (lat != 62) begin failures++; $display("FAIL held_latency got=%0d exp=62", lat); end
        if (new_block !== pt) begin failures++; $display("FAIL held_result got=%h exp=%h", new_block, pt); end
        @(negedge clk);
        next = 1'b0;
        checks += 2;
        if (ready !== 1'b0) begin failures++; $display("FAIL held_restart_ready got=%b exp=0", ready); end
        if (round !== 4'd10) begin failures++; $display("FAIL held_restart_round got=%0d exp=10", round); end
        wait_ready(1, lat);
        checks += 2;
        if (lat != 62) begin failures++; $display("FAIL held_again_latency got=%0d exp=62", lat); end
        if (new_block !== pt) begin failures++; $display("FAIL held_again_result got=%h exp=%h", new_block, pt); end
    endtask

    task automatic test_block_change();
        int lat;
        logic [127:0] ct, pt;
        ct = {$urandom, $urandom, $urandom, $urandom};
        model_decrypt(ct, pt);
        start(ct);
        @(negedge clk);
        block = ~ct;
        wait_ready(2, lat);
        checks += 2;
        if (lat != 62) begin failures++; $display("FAIL blkchg_latency got=%0d exp=62", lat); end
        if (new_block !== pt) begin failures++; $display("FAIL blkchg_result got=%h exp=%h", new_block, pt); end
    endtask

    task automatic test_reset_mid();
        int lat;
        set_key(KEY_B);
        start(CT_B);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks += 4;
        if (ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b exp=1", ready); end
        if (new_block !== '0) begin failures++; $display("FAIL mid_reset_block got=%h exp=0", new_block); end
        if (round !== 4'd0) begin failures++; $display("FAIL mid_reset_round got=%0d exp=0", round); end
        if (inv_sbox !== '0) begin failures++; $display("FAIL mid_reset_sbox got=%h exp=0", inv_sbox); end
`ifdef AES_DEC_DONE_PULSE_EN
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL mid_reset_done got=%b exp=0", done); end
`endif
        reset = 1'b1;
        next = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        next = 1'b0;
        checks += 2;
        if (ready !== 1'b1) begin failures++; $display("FAIL reset_wins_ready got=%b exp=1", ready); end
        if (round !== 4'd0) begin failures++; $display("FAIL reset_wins_round got=%0d exp=0", round); end
        start(CT_B);
        wait_ready(1, lat);
        checks += 2;
        if (lat != 62) begin failures++; $display("FAIL post_reset_latency got=%0d exp=62", lat); end
        if (new_block !== PT_B) begin failures++; $display("FAIL post_reset_result got=%h exp=%h", new_block, PT_B); end
    endtask

    task automatic test_random();
        int lat;
        logic [127:0] key, ct, pt;
        for (int n = 0; n < 6; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            ct  = {$urandom, $urandom, $urandom, $urandom};
            set_key(key);
            model_decrypt(ct, pt);
            start(ct);
            wait_ready(1, lat);
            checks += 2;
            if (lat != 62) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=62", n, lat); end
            if (new_block !== pt) begin failures++; $display("FAIL rand_result n=%0d got=%h exp=%h", n, new_block, pt); end
            block = ~ct;
            repeat (3) @(negedge clk);
            checks += 2;
            if (new_block !== pt) begin failures++; $display("FAIL rand_hold n=%0d got=%h exp=%h", n, new_block, pt); end
            if (ready !== 1'b1) begin failures++; $display("FAIL rand_idle n=%0d got=%b exp=1", n, ready); end
        end
    endtask

    initial begin
        reset = 1'b1;
        next = 1'b0;
        block = '0;
        build_tables();
        set_key(KEY_B);
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_round_trace();
        test_busy_next();
        test_held_next();
        test_block_change();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
